// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Entries carry the fetch address alongside the returned instruction word.
package fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W = 64;
  localparam logic [PC_W-1:0] PC_STEP = 64'd4;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of fetch entries with flush and a registered head.
// The head register is refreshed from next-state pointers, so a push is visible one cycle later.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fetch_entry_t             head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  head_q, head_d;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      // New head is either already stored or is the entry being written right now.
      if (count_d != '0) begin
        head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head       = head_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Fetch front end: issues in-order word requests, buffers responses, and flushes on redirect.
// Responses still in flight at a redirect are counted in drop_cnt and discarded in DRAIN.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [63:0] out_pc,
  output logic [63:0] out_pc4,
  input  logic        out_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_OCC = (CW + 1)'(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            req_fire, resp_fire, push, pop, head_valid;
  fetch_entry_t    head, push_data;

  assign occupancy      = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign imem_req_valid = !reset && (state_q == FETCH) && (occupancy < DEPTH_OCC);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign resp_fire = imem_resp_valid && (outstanding_q != '0);
  assign push      = (state_q == FETCH) && resp_fire && !redirect_valid;
  assign pop       = head_valid && out_ready && !redirect_valid;
  assign push_data = '{pc: resp_pc_q, inst: imem_resp_inst};

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_fire);

    if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;

    unique case (state_q)
      FETCH: begin
        if (resp_fire) resp_pc_d = resp_pc_q + PC_STEP;
      end
      DRAIN: begin
        if (resp_fire) drop_cnt_d = drop_cnt_q - CW'(1);
        if (drop_cnt_d == '0) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Everything still outstanding after this cycle belongs to the old stream.
    if (redirect_valid) begin
      drop_cnt_d = outstanding_d;
      fetch_pc_d = align_pc(redirect_pc);
      resp_pc_d  = align_pc(redirect_pc);
      state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (fifo_count),
    .head_valid(head_valid),
    .head      (head)
  );

  assign out_valid = head_valid;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign out_pc4   = head.pc + PC_STEP;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: in-order memory model with random latency and a
// transaction-level model of delivered and discarded fetch streams.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic [63:0] out_pc4;
  logic        out_ready;

  always #5 clock = ~clock;

  inst_fetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_inst (imem_resp_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_pc4        (out_pc4),
    .out_ready      (out_ready)
  );

  typedef struct {
    logic [63:0] addr;
    int unsigned due;
    bit          stale;
  } mem_txn_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_entry_t;

  typedef struct {
    logic [63:0] rpc;
    logic [63:0] exp_addr;
    logic [63:0] exp_pc4;
  } redir_vec_t;

  mem_txn_t    mem_q[$];
  exp_entry_t  deliv_q[$];
  logic [63:0] exp_pc;
  int unsigned cyc, checks, failures, acc_cnt, pop_cnt;
  bit          g_rdy, g_ordy, g_redir, g_jitter;
  logic [63:0] g_rpc;
  int unsigned g_lat_min, g_lat_max;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    logic [31:0] h;
    h = a[31:0] ^ a[63:32];
    return (h * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (mem_q[i]) if (mem_q[i].stale) n++;
    return n;
  endfunction

  function automatic int live_cnt();
    return mem_q.size() - stale_cnt();
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s cycle=%0d actual=timeout required=event", name, cyc);
  endtask

  // One clock cycle; entered and left at the falling edge.
  task automatic step();
    bit         rsp, acc, pop;
    mem_txn_t   t;
    exp_entry_t e;
    rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc) && (!g_jitter || $urandom_range(3) != 0);
    imem_resp_valid = rsp;
    imem_resp_inst  = rsp ? inst_of(mem_q[0].addr) : 32'h0;
    imem_req_ready  = g_rdy;
    out_ready       = g_ordy;
    redirect_valid  = g_redir;
    redirect_pc     = g_rpc;
    #1;
    chk("req_valid", 64'(imem_req_valid),
        64'((stale_cnt() == 0) && (deliv_q.size() + live_cnt() < DEPTH)));
    if (imem_req_valid) chk("req_addr", imem_req_addr, exp_pc);
    chk("out_valid", 64'(out_valid), 64'(deliv_q.size() != 0));
    if (out_valid && deliv_q.size() != 0) begin
      chk("out_pc", out_pc, deliv_q[0].pc);
      chk("out_inst", 64'(out_inst), 64'(deliv_q[0].inst));
      chk("out_pc4", out_pc4, deliv_q[0].pc + 64'd4);
    end
    acc = imem_req_valid && imem_req_ready;
    pop = out_valid && out_ready && !redirect_valid;
    if (rsp) begin
      t = mem_q.pop_front();
      if (!t.stale) begin
        e.pc   = t.addr;
        e.inst = inst_of(t.addr);
        deliv_q.push_back(e);
      end
    end
    if (pop) begin
      pop_cnt++;
      if (deliv_q.size() != 0) void'(deliv_q.pop_front());
    end
    if (acc) begin
      acc_cnt++;
      t.addr  = imem_req_addr;
      t.due   = cyc + $urandom_range(g_lat_max, g_lat_min);
      t.stale = 1'b0;
      mem_q.push_back(t);
      exp_pc = exp_pc + 64'd4;
    end
    if (redirect_valid) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      deliv_q.delete();
      exp_pc = {g_rpc[63:2], 2'b00};
    end
    @(negedge clock);
    cyc++;
  endtask

  task automatic apply_reset();
    reset           = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_inst  = 32'h0;
    redirect_valid  = 1'b0;
    imem_req_ready  = 1'b0;
    out_ready       = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", 64'(out_inst), 64'd0);
    mem_q.delete();
    deliv_q.delete();
    exp_pc = RESET_PC;
    repeat (2) @(negedge clock);
    reset   = 1'b0;
    cyc     = 0;
    acc_cnt = 0;
    pop_cnt = 0;
    g_redir = 1'b0;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 40; i++) begin
      if (imem_req_valid) return;
      step();
    end
    timeout(name);
  endtask

  task automatic wait_out(input string name);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) return;
      step();
    end
    timeout(name);
  endtask

  task automatic set_lat(input int unsigned lo, input int unsigned hi);
    g_lat_min = lo;
    g_lat_max = hi;
  endtask

  redir_vec_t vecs[4];

  initial begin
    reset = 1'b1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_inst = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; out_ready = 1'b0;
    g_rdy = 1'b1; g_ordy = 1'b1; g_redir = 1'b0; g_jitter = 1'b0; g_rpc = 64'h0;
    checks = 0; failures = 0; cyc = 0;
    set_lat(1, 1);

    vecs[0] = '{64'h0000_0000_0000_0203, 64'h0000_0000_0000_0200, 64'h0000_0000_0000_0204};
    vecs[1] = '{64'h0000_0000_0000_1001, 64'h0000_0000_0000_1000, 64'h0000_0000_0000_1004};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_0000};
    vecs[3] = '{64'h8000_0000_0000_0013, 64'h8000_0000_0000_0010, 64'h8000_0000_0000_0014};

    @(negedge clock);
    apply_reset();

    // Straight-line fetch: one delivered beat per cycle once the pipe is full.
    set_lat(1, 1); g_rdy = 1; g_ordy = 1;
    repeat (10) step();
    pop_cnt = 0;
    repeat (10) step();
    chk("t1_throughput", 64'(pop_cnt), 64'd10);

    // Consumer stalled: exactly DEPTH requests, then resume one cycle after the first pop.
    apply_reset();
    g_ordy = 0;
    repeat (10) step();
    chk("t2_accepts", 64'(acc_cnt), 64'd4);
    chk("t2_stalled", 64'(imem_req_valid), 64'd0);
    g_ordy = 1;
    step();
    chk("t2_resume", 64'(imem_req_valid), 64'd1);
    g_ordy = 0;
    repeat (8) step();
    chk("t2_full_out_valid", 64'(out_valid), 64'd1);
    apply_reset();

    // Redirect with three responses in flight.
    set_lat(3, 3); g_ordy = 1;
    repeat (3) step();
    g_redir = 1; g_rpc = 64'h100;
    step();
    g_redir = 0;
    for (int i = 0; i < 40 && !imem_req_valid; i++) begin
      chk("t3_drop_out_valid", 64'(out_valid), 64'd0);
      step();
    end
    wait_req("t3_wait_req");
    chk("t3_first_addr", imem_req_addr, 64'h100);
    wait_out("t3_wait_out");
    chk("t3_first_pc", out_pc, 64'h100);

    // Redirect coincides with a pop, a request accept and a response.
    apply_reset();
    set_lat(1, 1); g_ordy = 0;
    repeat (2) step();
    chk("t4_pre_out", 64'(out_valid), 64'd1);
    chk("t4_pre_req", 64'(imem_req_valid), 64'd1);
    g_ordy = 1; g_redir = 1; g_rpc = 64'h203;
    step();
    g_redir = 0;
    chk("t4_no_repeat", 64'(out_valid), 64'd0);
    wait_req("t4_wait_req");
    chk("t4_addr", imem_req_addr, 64'h200);
    wait_out("t4_wait_out");
    chk("t4_pc", out_pc, 64'h200);

    // Second redirect while still draining the first.
    apply_reset();
    set_lat(3, 3);
    repeat (3) step();
    g_redir = 1; g_rpc = 64'h300;
    step();
    chk("t5_draining", 64'(imem_req_valid), 64'd0);
    g_rpc = 64'h400;
    step();
    g_redir = 0;
    wait_req("t5_wait_req");
    chk("t5_addr", imem_req_addr, 64'h400);
    wait_out("t5_wait_out");
    chk("t5_pc", out_pc, 64'h400);
    repeat (8) step();

    // Reset in the middle of a drain.
    apply_reset();
    set_lat(3, 3);
    repeat (3) step();
    g_redir = 1; g_rpc = 64'h500;
    step();
    g_redir = 0;
    step();
    chk("t6_in_drain", 64'(imem_req_valid), 64'd0);
    apply_reset();
    #1;
    chk("t6_restart_valid", 64'(imem_req_valid), 64'd1);
    chk("t6_restart_addr", imem_req_addr, RESET_PC);
    @(negedge clock);
    apply_reset();

    // Table of redirect targets: alignment and 64-bit wrap of pc+4.
    set_lat(2, 2); g_rdy = 1; g_ordy = 1;
    foreach (vecs[v]) begin
      repeat (3) step();
      g_redir = 1; g_rpc = vecs[v].rpc;
      step();
      g_redir = 0;
      wait_req("tv_wait_req");
      chk("tv_addr", imem_req_addr, vecs[v].exp_addr);
      wait_out("tv_wait_out");
      chk("tv_pc", out_pc, vecs[v].exp_addr);
      chk("tv_pc4", out_pc4, vecs[v].exp_pc4);
      repeat (4) step();
    end

    // Random traffic against the model.
    apply_reset();
    set_lat(1, 4); g_jitter = 1;
    for (int i = 0; i < 3000; i++) begin
      g_rdy   = ($urandom_range(9) < 7);
      g_ordy  = ($urandom_range(9) < 6);
      g_redir = ($urandom_range(99) < 3);
      g_rpc   = {$urandom, $urandom};
      if ($urandom_range(9) == 0) g_rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
      step();
    end
    g_redir = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
